// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and transmitter/receiver FSM encoding.
package uart_pkg;

  // Default frame format: 8 data bits, 50 MHz clock at 9600 baud.
  localparam int NB_DATA_DEF      = 8;
  localparam int CLKS_PER_BIT_DEF = 5208;

  // 2-bit FSM encoding, kept explicit so the receiver and glue logic can share it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB-first, one stop bit.
// Every output is a register, so the TX pin never glitches on next-state logic.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_start,
  input  logic [NB_DATA-1:0] tx_data,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB_DATA - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  uart_state_t        r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [BIT_W-1:0]   r_bit, w_bit_next;
  logic [NB_DATA-1:0] r_shift, w_shift_next;
  logic               r_tx, w_tx_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               w_bit_end;

  // The current serial bit has been held for its full CLKS_PER_BIT cycles.
  assign w_bit_end = (r_cnt == CNT_LAST);

  // State and output registers; reset drops the frame and idles the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and next-output logic; tx_done is a pulse, so it defaults low.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        if (tx_start) begin
          // Capture the word now; later tx_data changes cannot affect the frame.
          w_shift_next = tx_data;
          w_state_next = START;
          w_tx_next    = 1'b0;
          w_busy_next  = 1'b1;
          w_cnt_next   = '0;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
          w_bit_next   = '0;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit == BIT_LAST) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            // Drive the next bit straight from the pre-shift register.
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];
            w_bit_next   = r_bit + BIT_ONE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, NB_DATA=8.
module tb_uart_tx;

  localparam int NB    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (NB + 2) * CPB;

  logic          clk;
  logic          rst_n;
  logic          tx_start;
  logic [NB-1:0] tx_data;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0;

  uart_tx #(
    .NB_DATA      (NB),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running edge count used to measure start-to-start spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word with tx_start for one edge; returns 1 time unit after E0.
  task automatic send(input logic [NB-1:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    tick();
    tx_start = 1'b0;
  endtask

  // Line must sit idle-high, not busy, with no done pulse.
  task automatic idle_check(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_tx[%0d]", name, k), 32'(tx), 32'd1);
      check($sformatf("%s_busy[%0d]", name, k), 32'(tx_busy), 32'd0);
      check($sformatf("%s_done[%0d]", name, k), 32'(tx_done), 32'd0);
      tick();
    end
  endtask

  // Check ncyc cycles of a frame starting at E0+1; seq[i] is the line level
  // during bit slot i (slot 0 = start bit). Optionally pulses tx_start=0x3C
  // mid-frame. A full frame also checks the completion edge E0+FRAME.
  task automatic watch(input string name, input logic [9:0] seq, input int ncyc, input int inj);
    for (int k = 0; k < ncyc; k++) begin
      check($sformatf("%s_tx[%0d]", name, k), 32'(tx), 32'(seq[k / CPB]));
      check($sformatf("%s_busy[%0d]", name, k), 32'(tx_busy), 32'd1);
      check($sformatf("%s_done[%0d]", name, k), 32'(tx_done), 32'd0);
      if (k == inj) begin
        tx_start = 1'b1;
        tx_data  = 8'h3C;
      end else if (k == inj + 1) begin
        tx_start = 1'b0;
      end
      tick();
    end
    if (ncyc == FRAME) begin
      check($sformatf("%s_end_tx", name), 32'(tx), 32'd1);
      check($sformatf("%s_end_busy", name), 32'(tx_busy), 32'd0);
      check($sformatf("%s_end_done", name), 32'(tx_done), 32'd1);
    end
    $display("frame %s: %0d cycles observed, errors so far %0d", name, ncyc, n_errors);
  endtask

  initial begin
    rst_n    = 1'b1;
    tx_start = 1'b0;
    tx_data  = '0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(tx_busy), 32'd0);
    check("rst_async_done", 32'(tx_done), 32'd0);
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    idle_check("post_rst", 5);

    // Single frame 0xA5: 0,1,0,1,0,0,1,0,1,1.
    send(8'hA5);
    watch("A5", 10'b1101001010, FRAME, -1);
    tick();
    idle_check("A5_after", 10);

    // 0xA5 again with a 0x3C request during data bit 2; must be ignored.
    send(8'hA5);
    watch("A5_busy_start", 10'b1101001010, FRAME, 13);
    tick();
    idle_check("ignored_start", 12);

    // Back-to-back: 0xA5 then 0x0F requested in the tx_done cycle.
    send(8'hA5);
    t0 = cyc;
    watch("A5_b2b", 10'b1101001010, FRAME, -1);
    send(8'h0F);
    check("b2b_spacing", 32'(cyc - t0), 32'd41);
    watch("0F", 10'b1000011110, FRAME, -1);
    tick();
    idle_check("0F_after", 5);

    // Reset during data bit 3 of 0x5A truncates the frame.
    send(8'h5A);
    watch("5A_trunc", 10'b1010110100, 17, -1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    idle_check("midrst_idle", 45);

    // Frame after the truncated one is intact.
    send(8'hFF);
    watch("FF", 10'b1111111110, FRAME, -1);
    tick();
    idle_check("FF_after", 3);

    // ALU ADD 0x12 + 0x34 = 0x46: data bits 0,1,1,0,0,0,1,0.
    send(8'h12 + 8'h34);
    watch("alu_46", 10'b1010001100, FRAME, -1);
    tick();
    idle_check("alu_after", 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
